// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences fetch/decode/execute over one memory port.
// Define MEM_TIMEOUT_EN to bound every memory wait (MEM_TIMEOUT cycles) and halt when it expires.
module multicycle_control #(
`ifdef MEM_TIMEOUT_EN
  parameter int unsigned MEM_TIMEOUT = 15,
`endif
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   iord,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   branch_ne,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [2:0]             ALUop,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t state;
  state_t state_next;
  logic   mem_wait;
  logic   timeout_hit;
  logic   retire;

  // The branch condition is resolved in the datapath; the FSM never looks at zero.
  logic   unused_zero;
  assign unused_zero = zero;

  assign mem_wait = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;

  assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                  (state == JUMP) || ((state == MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    ALUop         = 3'b000;

    case (state)
      IDLE: state_next = FETCH;

      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        // PC+4 and the IR load commit only in the cycle memory delivers the word.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW: state_next = EXEC;
          OP_BEQ, OP_BNE:                                        state_next = BRANCH;
          OP_J:                                                  state_next = JUMP;
          default:                                               state_next = HALT;
        endcase
      end

      EXEC: begin
        alu_src_a = 1'b1;
        if (opcode == OP_R) begin
          alu_src_b = 2'b00;
          ALUop     = 3'b111;
        end else begin
          alu_src_b = 2'b10;
          case (opcode)
            OP_ANDI: ALUop = 3'b110;
            OP_ORI:  ALUop = 3'b010;
            OP_SLTI: ALUop = 3'b011;
            default: ALUop = 3'b000;
          endcase
        end
        case (opcode)
          OP_LW:   state_next = MEM_RD;
          OP_SW:   state_next = MEM_WR;
          default: state_next = WB_ALU;
        endcase
      end

      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = WB_MEM;
      end

      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = FETCH;
      end

      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_R);
        state_next = FETCH;
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end

      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = opcode[0];
        state_next    = FETCH;
      end

      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        state_next = FETCH;
      end

      HALT: state_next = HALT;

      default: state_next = IDLE;
    endcase

    if (timeout_hit) state_next = HALT;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // Counts consecutive stalled cycles within one state; any transition restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (mem_wait) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  logic unused_mem_wait;
  assign unused_mem_wait = mem_wait;
  assign timeout_hit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state_next == HALT) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: CPI/decode table, instruction-level trace model, directed corners.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] ALUop;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         cpi;
    logic [2:0] alu2;
    logic [1:0] srcb2;
    logic       bne2;
    logic       rw_last;
    logic       rdst_last;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  ALUop;
  logic [31:0] instr_count;

  int          n_checks;
  int          n_fail;
  logic [31:0] cnt_m;
  bit          model_retires;
  outs_t       exp_q[$];
  bit          rdy_q[$];
  vec_t        tbl[10];
  logic [5:0]  legal_ops[10];

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .ALUop(ALUop), .illegal(illegal), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic outs_t get_outs();
    outs_t o;
    o.mem_req = mem_req;     o.mem_we = mem_we;         o.iord = iord;
    o.ir_write = ir_write;   o.pc_write = pc_write;     o.pc_write_cond = pc_write_cond;
    o.branch_ne = branch_ne; o.reg_write = reg_write;   o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.pc_source = pc_source; o.ALUop = ALUop;           o.illegal = illegal;
    return o;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU operation the execute step must request, per instruction; 0 return = not executed via ALU step.
  function automatic bit alu_code(input logic [5:0] op, output logic [2:0] code);
    code = 3'b000;
    case (op)
      OP_R:                  code = 3'b111;
      OP_ANDI:               code = 3'b110;
      OP_ORI:                code = 3'b010;
      OP_SLTI:               code = 3'b011;
      OP_ADDI, OP_LW, OP_SW: code = 3'b000;
      default:               return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic add(input outs_t o, input bit rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  // Reference trace: one expected output vector per cycle for a whole instruction.
  task automatic build(input logic [5:0] op, input int fd, input int md, input int halt_cycles);
    outs_t o;
    logic [2:0] code;
    exp_q.delete();
    rdy_q.delete();
    model_retires = 1'b1;
    for (int i = 0; i < fd; i++) begin
      o = '0; o.mem_req = 1'b1; o.alu_src_b = 2'b01;
      add(o, 1'b0);
    end
    o = '0; o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
    add(o, 1'b1);
    o = '0; o.alu_src_b = 2'b11;
    add(o, 1'($urandom_range(0, 1)));
    if (op == OP_BEQ || op == OP_BNE) begin
      o = '0; o.alu_src_a = 1'b1; o.ALUop = 3'b001; o.pc_write_cond = 1'b1;
      o.pc_source = 2'b01; o.branch_ne = (op == OP_BNE);
      add(o, 1'($urandom_range(0, 1)));
    end else if (op == OP_J) begin
      o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10;
      add(o, 1'($urandom_range(0, 1)));
    end else if (alu_code(op, code)) begin
      o = '0; o.alu_src_a = 1'b1; o.ALUop = code; o.alu_src_b = (op == OP_R) ? 2'b00 : 2'b10;
      add(o, 1'($urandom_range(0, 1)));
      if (op == OP_LW || op == OP_SW) begin
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == OP_SW);
        for (int i = 0; i < md; i++) add(o, 1'b0);
        add(o, 1'b1);
        if (op == OP_LW) begin
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          add(o, 1'($urandom_range(0, 1)));
        end
      end else begin
        o = '0; o.reg_write = 1'b1; o.reg_dst = (op == OP_R);
        add(o, 1'($urandom_range(0, 1)));
      end
    end else begin
      model_retires = 1'b0;
      o = '0; o.illegal = 1'b1;
      for (int i = 0; i < halt_cycles; i++) add(o, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fd, input int md,
                           input int halt_cycles, input int limit, input string tag);
    int n;
    build(op, fd, md, halt_cycles);
    n = (limit >= 0 && limit < exp_q.size()) ? limit : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      opcode = op; zero = z; mem_ready = rdy_q[i];
      #1;
      if (i == 0) check_val({tag, "_count_in"}, 64'(instr_count), 64'(cnt_m));
      check_val($sformatf("%s_cyc%0d_outs", tag, i), 64'(get_outs()), 64'(exp_q[i]));
    end
    if (n == exp_q.size()) begin
      if (model_retires) cnt_m++;
      else check_val({tag, "_count_frozen"}, 64'(instr_count), 64'(cnt_m));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check_val("reset_outs", 64'(get_outs()), 64'd0);
    check_val("reset_count", 64'(instr_count), 64'd0);
    cnt_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("idle_outs", 64'(get_outs()), 64'd0);
  endtask

  initial begin
    outs_t s2, sl, cur;
    int    cyc;
    bit    found;
    outs_t halt_o;

    rst_n = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    n_checks = 0; n_fail = 0; cnt_m = '0;

    //          op       cpi alu2    srcb2  bne2  rw_last rdst_last
    tbl[0] = '{OP_R,    4, 3'b111, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{OP_ADDI, 4, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{OP_ANDI, 4, 3'b110, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{OP_ORI,  4, 3'b010, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{OP_SLTI, 4, 3'b011, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{OP_LW,   5, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{OP_SW,   4, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{OP_BEQ,  3, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{OP_BNE,  3, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{OP_J,    3, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) legal_ops[k] = tbl[k].op;

    do_reset();

    // Table: mem_ready held high, measure FETCH-to-FETCH length and key decode fields.
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      opcode = tbl[k].op; mem_ready = 1'b1; zero = 1'($urandom_range(0, 1));
      #1;
      cyc = 0; found = 1'b0; s2 = '0; sl = '0;
      while (!found && cyc < 10) begin
        @(negedge clk);
        #1;
        cyc++;
        cur = get_outs();
        if (cyc == 2) s2 = cur;
        if (cur.mem_req && !cur.iord) found = 1'b1;
        else sl = cur;
      end
      check_val($sformatf("tbl%0d_cpi", k), found ? 64'(cyc) : 64'hdead, 64'(tbl[k].cpi));
      check_val($sformatf("tbl%0d_aluop", k), 64'(s2.ALUop), 64'(tbl[k].alu2));
      check_val($sformatf("tbl%0d_srcb", k), 64'(s2.alu_src_b), 64'(tbl[k].srcb2));
      check_val($sformatf("tbl%0d_bne", k), 64'(s2.branch_ne), 64'(tbl[k].bne2));
      check_val($sformatf("tbl%0d_regwrite", k), 64'(sl.reg_write), 64'(tbl[k].rw_last));
      check_val($sformatf("tbl%0d_regdst", k), 64'(sl.reg_dst), 64'(tbl[k].rdst_last));
      check_val($sformatf("tbl%0d_count", k), 64'(instr_count), 64'(k + 1));
    end

    do_reset();
    run_instr(OP_R,    1'b0, 0, 0, 0, -1, "add");
    run_instr(OP_LW,   1'b0, 3, 3, 0, -1, "lw_slow");
    run_instr(OP_BEQ,  1'b1, 0, 0, 0, -1, "beq_z1");
    run_instr(OP_BNE,  1'b1, 0, 0, 0, -1, "bne_z1");
    run_instr(OP_ANDI, 1'b0, 0, 0, 0, -1, "andi");
    run_instr(OP_ORI,  1'b0, 0, 0, 0, -1, "ori");

    for (int r = 0; r < 150; r++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 0, -1, $sformatf("rnd%0d", r));
    end

    run_instr(6'b111111, 1'b0, 1, 0, 20, -1, "halt");
    do_reset();
    run_instr(OP_ADDI, 1'b0, 1, 0, 0, -1, "after_halt");

    // Reset while a store is waiting on memory: request must drop asynchronously.
    run_instr(OP_SW, 1'b0, 0, 6, 0, 5, "sw_cut");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midreset_mem_req", 64'(mem_req), 64'd0);
    check_val("midreset_mem_we", 64'(mem_we), 64'd0);
    check_val("midreset_outs", 64'(get_outs()), 64'd0);
    do_reset();
    run_instr(OP_SW, 1'b0, 1, 1, 0, -1, "sw_restart");

`ifdef MEM_TIMEOUT_EN
    run_instr(OP_SW, 1'b0, 0, 15, 0, 18, "sw_timeout");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    halt_o = '0; halt_o.illegal = 1'b1;
    check_val("timeout_halt_outs", 64'(get_outs()), 64'(halt_o));
    check_val("timeout_count", 64'(instr_count), 64'(cnt_m));
    do_reset();
`else
    halt_o = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
